// File: rtl/mips_bus_arbiter.sv
`default_nettype none
// mips_bus_arbiter: fetch/data two-master arbiter onto one Avalon-style slave bus.
// Optional stall watchdog enabled by defining MIPS_ARB_TIMEOUT_EN.  Revision 1.0
module mips_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2
  } state_t;

  state_t     r_state;
  logic [1:0] r_grant;
  logic       w_d_req;
  logic       w_timeout;
  logic       w_done;

  assign w_d_req = d_read | d_write;
  assign w_done  = (r_state != S_IDLE) && (!waitrequest || w_timeout);
  assign grant   = r_grant;

`ifdef MIPS_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout_err;

  // Counter holds the number of earlier stalled cycles, so the abort lands on the Nth stall.
  assign w_timeout = (r_state != S_IDLE) && waitrequest &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == S_IDLE || !waitrequest || w_timeout)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      if (w_timeout)
        r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  logic w_unused;
  assign w_unused    = ^TIMEOUT_CYCLES;
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_grant <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_d_req) begin
            r_state <= S_BUSY_D;
            r_grant <= 2'b10;
          end else if (i_read) begin
            r_state <= S_BUSY_I;
            r_grant <= 2'b01;
          end
        end
        S_BUSY_I: begin
          if (!i_read) begin
            r_state <= S_IDLE;
            r_grant <= 2'b00;
          end else if (w_done) begin
            r_state <= w_d_req ? S_BUSY_D : S_IDLE;
            r_grant <= w_d_req ? 2'b10 : 2'b00;
          end
        end
        S_BUSY_D: begin
          if (!w_d_req) begin
            r_state <= S_IDLE;
            r_grant <= 2'b00;
          end else if (w_done) begin
            r_state <= i_read ? S_BUSY_I : S_IDLE;
            r_grant <= i_read ? 2'b01 : 2'b00;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= 2'b00;
        end
      endcase
    end
  end

  // Bus is a pure function of state so an async reset releases it without a clock.
  always_comb begin
    address       = '0;
    read          = 1'b0;
    write         = 1'b0;
    writedata     = '0;
    byteenable    = '0;
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    i_readdata    = '0;
    d_readdata    = '0;
    case (r_state)
      S_BUSY_I: begin
        address       = i_address;
        read          = i_read & ~w_timeout;
        byteenable    = 4'hF;
        i_waitrequest = waitrequest & ~w_timeout;
        i_readdata    = w_timeout ? 32'h0 : readdata;
      end
      S_BUSY_D: begin
        address       = d_address;
        writedata     = d_writedata;
        byteenable    = d_byteenable;
        write         = d_write & ~w_timeout;
        read          = d_read & ~d_write & ~w_timeout;
        d_waitrequest = waitrequest & ~w_timeout;
        d_readdata    = w_timeout ? 32'h0 : readdata;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_bus_arbiter.sv
`default_nettype none
// tb_mips_bus_arbiter: directed scenarios plus randomized two-master traffic
// checked against a shadow memory and the arbitration rules.
module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] i_address, d_address, d_writedata, address, writedata, readdata;
  logic [31:0] i_readdata, d_readdata;
  logic        i_read, d_read, d_write, i_waitrequest, d_waitrequest;
  logic        read, write, waitrequest, timeout_err, slv_wait;
  logic [3:0]  d_byteenable, byteenable;
  logic [1:0]  grant;
  logic [31:0] mem    [0:1023];
  logic [31:0] shadow [0:1023];
  int          checks = 0;
  int          errors = 0;

  mips_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .i_address(i_address), .i_read(i_read), .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_writedata(d_writedata),
    .d_byteenable(d_byteenable), .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
    .address(address), .read(read), .write(write), .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata), .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  assign waitrequest = slv_wait;
  assign readdata    = mem[address[11:2]];

  always @(posedge clk) begin
    if (write && !waitrequest)
      for (int b = 0; b < 4; b++)
        if (byteenable[b]) mem[address[11:2]][8*b +: 8] <= writedata[8*b +: 8];
  end

  task automatic idle_inputs();
    i_read = 0; d_read = 0; d_write = 0; slv_wait = 0;
    i_address = '0; d_address = '0; d_writedata = '0; d_byteenable = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (read !== 1'b0) begin errors++; $display("FAIL reset_read got %h exp 0", read); end
    checks++; if (write !== 1'b0) begin errors++; $display("FAIL reset_write got %h exp 0", write); end
    checks++; if (byteenable !== 4'h0) begin errors++; $display("FAIL reset_be got %h exp 0", byteenable); end
    checks++; if (address !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", address); end
    checks++; if (writedata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", writedata); end
    checks++; if (i_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_i_wait got %h exp 1", i_waitrequest); end
    checks++; if (d_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_d_wait got %h exp 1", d_waitrequest); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", grant); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr got %h exp 0", timeout_err); end
    reset = 1;
    @(negedge clk); #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL post_reset_grant got %b exp 00", grant); end
  endtask

  task automatic test_fetch();
    @(negedge clk);
    mem[4] <= 32'h8C02_0004;
    i_address = 32'h10; i_read = 1; slv_wait = 0;
    #1;
    checks++; if (read !== 1'b0) begin errors++; $display("FAIL fetch_n_read got %h exp 0", read); end
    checks++; if (i_waitrequest !== 1'b1) begin errors++; $display("FAIL fetch_n_wait got %h exp 1", i_waitrequest); end
    @(negedge clk); #1;
    checks++; if (read !== 1'b1) begin errors++; $display("FAIL fetch_read got %h exp 1", read); end
    checks++; if (address !== 32'h10) begin errors++; $display("FAIL fetch_addr got %h exp 10", address); end
    checks++; if (byteenable !== 4'hF) begin errors++; $display("FAIL fetch_be got %h exp f", byteenable); end
    checks++; if (i_readdata !== 32'h8C02_0004) begin errors++; $display("FAIL fetch_data got %h exp 8c020004", i_readdata); end
    checks++; if (i_waitrequest !== 1'b0) begin errors++; $display("FAIL fetch_wait got %h exp 0", i_waitrequest); end
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL fetch_grant got %b exp 01", grant); end
    @(negedge clk);
    i_read = 0;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL fetch_done_grant got %b exp 00", grant); end
  endtask

  task automatic test_tie();
    @(negedge clk);
    mem[64] <= 32'h1122_3344;
    i_read = 1; i_address = 32'h20;
    d_write = 1; d_address = 32'h100; d_writedata = 32'hDEAD_BEEF; d_byteenable = 4'b0011;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tie_n_grant got %b exp 00", grant); end
    @(negedge clk); #1;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL tie_grant_d got %b exp 10", grant); end
    checks++; if (write !== 1'b1 || read !== 1'b0) begin errors++; $display("FAIL tie_rw got w%h r%h exp w1 r0", write, read); end
    checks++; if (address !== 32'h100) begin errors++; $display("FAIL tie_addr got %h exp 100", address); end
    checks++; if (byteenable !== 4'b0011) begin errors++; $display("FAIL tie_be got %b exp 0011", byteenable); end
    checks++; if (writedata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL tie_wdata got %h exp deadbeef", writedata); end
    checks++; if (d_waitrequest !== 1'b0 || i_waitrequest !== 1'b1) begin errors++; $display("FAIL tie_waits got d%h i%h exp d0 i1", d_waitrequest, i_waitrequest); end
    @(negedge clk);
    d_write = 0;
    #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL tie_grant_i got %b exp 01", grant); end
    checks++; if (read !== 1'b1 || address !== 32'h20) begin errors++; $display("FAIL tie_fetch_bus got r%h a%h exp r1 a20", read, address); end
    checks++; if (i_waitrequest !== 1'b0 || d_waitrequest !== 1'b1) begin errors++; $display("FAIL tie_fetch_waits got i%h d%h exp i0 d1", i_waitrequest, d_waitrequest); end
    @(negedge clk);
    i_read = 0;
    #1;
    checks++; if (mem[64] !== 32'h1122_BEEF) begin errors++; $display("FAIL tie_mem got %h exp 1122beef", mem[64]); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tie_end_grant got %b exp 00", grant); end
  endtask

  task automatic test_stall();
    @(negedge clk);
    mem[128] <= 32'hCAFE_F00D;
    d_read = 1; d_address = 32'h200; d_byteenable = 4'hF; slv_wait = 1;
    #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      checks++; if (d_waitrequest !== 1'b1) begin errors++; $display("FAIL stall_wait%0d got %h exp 1", k, d_waitrequest); end
      checks++; if (read !== 1'b1 || address !== 32'h200) begin errors++; $display("FAIL stall_bus%0d got r%h a%h exp r1 a200", k, read, address); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL stall_terr%0d got %h exp 0", k, timeout_err); end
    end
    @(negedge clk);
    slv_wait = 0;
    #1;
    checks++; if (d_waitrequest !== 1'b0) begin errors++; $display("FAIL stall_release got %h exp 0", d_waitrequest); end
    checks++; if (d_readdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL stall_data got %h exp cafef00d", d_readdata); end
    @(negedge clk);
    d_read = 0;
    #1;
    checks++; if (grant !== 2'b00 || timeout_err !== 1'b0) begin errors++; $display("FAIL stall_end got g%b t%h exp g00 t0", grant, timeout_err); end
  endtask

  task automatic test_rw_both();
    @(negedge clk);
    d_read = 1; d_write = 1; d_address = 32'h104; d_writedata = 32'h0102_0304; d_byteenable = 4'hF;
    @(negedge clk); #1;
    checks++; if (write !== 1'b1 || read !== 1'b0) begin errors++; $display("FAIL rwboth got w%h r%h exp w1 r0", write, read); end
    @(negedge clk);
    d_read = 0; d_write = 0;
    #1;
    checks++; if (mem[65] !== 32'h0102_0304) begin errors++; $display("FAIL rwboth_mem got %h exp 01020304", mem[65]); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g [0:4];
    exp_g[0] = 2'b00; exp_g[1] = 2'b01; exp_g[2] = 2'b00; exp_g[3] = 2'b01; exp_g[4] = 2'b00;
    @(negedge clk);
    i_read = 1; i_address = 32'h40;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++; if (grant !== exp_g[k]) begin errors++; $display("FAIL b2b_grant%0d got %b exp %b", k, grant, exp_g[k]); end
    end
    @(negedge clk);
    i_read = 0;
    @(negedge clk); #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL b2b_drop_grant got %b exp 00", grant); end
  endtask

  task automatic test_random();
    logic        i_act, d_act, i_done, d_done;
    int          i_age, d_age, run_stall, completions;
    int unsigned kind;
    logic [9:0]  idx;
    for (int w = 0; w < 1024; w++) shadow[w] = mem[w];
    i_act = 0; d_act = 0; i_done = 0; d_done = 0;
    i_age = 0; d_age = 0; run_stall = 0; completions = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (i_done) begin i_act = 0; i_read = 0; i_done = 0; end
      if (d_done) begin d_act = 0; d_read = 0; d_write = 0; d_done = 0; end
      if (!i_act && $urandom_range(0, 2) == 0) begin
        i_act = 1; i_age = 0; i_read = 1;
        i_address = 32'h300 + ($urandom_range(0, 15) << 2);
      end
      if (!d_act && $urandom_range(0, 2) == 0) begin
        d_act = 1; d_age = 0; kind = $urandom_range(0, 2);
        d_read = (kind != 1); d_write = (kind != 0);
        d_address = 32'h300 + ($urandom_range(0, 15) << 2);
        d_writedata = $urandom; d_byteenable = 4'($urandom_range(1, 15));
      end
      if (run_stall < 2 && $urandom_range(0, 2) == 0) begin slv_wait = 1; run_stall++; end
      else begin slv_wait = 0; run_stall = 0; end
      #1;
      checks++; if (grant === 2'b11 || $isunknown(grant)) begin errors++; $display("FAIL rnd_grant_legal got %b", grant); end
      checks++; if (!i_waitrequest && !d_waitrequest) begin errors++; $display("FAIL rnd_both_served got i%h d%h", i_waitrequest, d_waitrequest); end
      if (grant == 2'b00) begin
        checks++; if (read || write || !i_waitrequest || !d_waitrequest) begin errors++; $display("FAIL rnd_idle_bus got r%h w%h i%h d%h exp r0 w0 i1 d1", read, write, i_waitrequest, d_waitrequest); end
      end else if (grant == 2'b01) begin
        checks++; if (address !== i_address || read !== 1'b1 || write !== 1'b0 || d_waitrequest !== 1'b1) begin
          errors++; $display("FAIL rnd_fetch_bus got a%h r%h w%h d%h exp a%h r1 w0 d1", address, read, write, d_waitrequest, i_address); end
      end else if (grant == 2'b10) begin
        checks++; if (address !== d_address || write !== d_write || read !== (d_read & ~d_write) || i_waitrequest !== 1'b1) begin
          errors++; $display("FAIL rnd_data_bus got a%h r%h w%h i%h exp a%h", address, read, write, i_waitrequest, d_address); end
      end
      if (i_act && !i_waitrequest) begin
        idx = i_address[11:2];
        checks++; if (i_readdata !== shadow[idx]) begin errors++; $display("FAIL rnd_fetch_data got %h exp %h", i_readdata, shadow[idx]); end
        i_done = 1; completions++;
      end else if (i_act) begin
        i_age++;
        checks++; if (i_age > 15) begin errors++; $display("FAIL rnd_fetch_starve got %0d exp <=15", i_age); end
      end
      if (d_act && !d_waitrequest) begin
        idx = d_address[11:2];
        if (d_write) begin
          for (int b = 0; b < 4; b++) if (d_byteenable[b]) shadow[idx][8*b +: 8] = d_writedata[8*b +: 8];
        end else begin
          checks++; if (d_readdata !== shadow[idx]) begin errors++; $display("FAIL rnd_load_data got %h exp %h", d_readdata, shadow[idx]); end
        end
        d_done = 1; completions++;
      end else if (d_act) begin
        d_age++;
        checks++; if (d_age > 15) begin errors++; $display("FAIL rnd_data_starve got %0d exp <=15", d_age); end
      end
    end
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (completions < 100) begin errors++; $display("FAIL rnd_progress got %0d exp >=100", completions); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rnd_end_grant got %b exp 00", grant); end
  endtask

`ifdef MIPS_ARB_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge clk);
    d_read = 1; d_address = 32'h200; d_byteenable = 4'hF; slv_wait = 1;
    #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      checks++; if (d_waitrequest !== 1'b1) begin errors++; $display("FAIL to_stall%0d got %h exp 1", k, d_waitrequest); end
    end
    @(negedge clk); #1;
    checks++; if (d_waitrequest !== 1'b0) begin errors++; $display("FAIL to_release got %h exp 0", d_waitrequest); end
    checks++; if (d_readdata !== 32'h0) begin errors++; $display("FAIL to_data got %h exp 0", d_readdata); end
    checks++; if (read !== 1'b0) begin errors++; $display("FAIL to_read got %h exp 0", read); end
    @(negedge clk);
    d_read = 0;
    #1;
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_flag got %h exp 1", timeout_err); end
    repeat (10) @(negedge clk);
    #1;
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %h exp 1", timeout_err); end
    slv_wait = 0;
  endtask
`else
  task automatic test_timeout();
    @(negedge clk);
    d_read = 1; d_address = 32'h200; d_byteenable = 4'hF; slv_wait = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      checks++; if (d_waitrequest !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL nto_stall%0d got w%h t%h exp w1 t0", k, d_waitrequest, timeout_err); end
    end
    @(negedge clk);
    slv_wait = 0;
    #1;
    checks++; if (d_waitrequest !== 1'b0) begin errors++; $display("FAIL nto_release got %h exp 0", d_waitrequest); end
    @(negedge clk);
    d_read = 0;
  endtask
`endif

  task automatic test_async_reset();
    @(negedge clk);
    d_write = 1; d_address = 32'h108; d_writedata = 32'h5555_AAAA; d_byteenable = 4'hF; slv_wait = 1;
    @(negedge clk); #1;
    checks++; if (write !== 1'b1) begin errors++; $display("FAIL ar_pre_write got %h exp 1", write); end
    #2;
    reset = 0;
    #1;
    checks++; if (write !== 1'b0) begin errors++; $display("FAIL ar_write got %h exp 0", write); end
    checks++; if (d_waitrequest !== 1'b1) begin errors++; $display("FAIL ar_d_wait got %h exp 1", d_waitrequest); end
    @(negedge clk);
    reset = 1; d_write = 0; slv_wait = 0;
    @(negedge clk); #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL ar_grant got %b exp 00", grant); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL ar_terr got %h exp 0", timeout_err); end
  endtask

  initial begin
    for (int w = 0; w < 1024; w++) mem[w] <= $urandom;
    test_reset();
    test_fetch();
    test_tie();
    test_stall();
    test_rw_both();
    test_back_to_back();
    test_random();
    test_timeout();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Two-master to one-slave arbiter sharing the single Avalon-style memory bus between the CPU's instruction-fetch port and its load/store data port. It sits between the `mips_cpu_bus` internals and the `RAM_8x4096` bus (`address`/`read`/`write`/`waitrequest`/`writedata`/`byteenable`/`readdata`). It grants one master at a time and holds the grant until the slave completes the transfer. An optional watchdog aborts slave transfers that stall too long.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum consecutive slave-stall cycles before abort. Used only with `MIPS_ARB_TIMEOUT_EN`.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `i_address`  in  32  fetch address
- `i_read`  in  1  fetch request; held until `i_waitrequest`=0
- `i_waitrequest`  out  1  fetch stall
- `i_readdata`  out  32  fetch data, valid when `i_read` && !`i_waitrequest`
- `d_address`  in  32  data address
- `d_read`  in  1  data read request
- `d_write`  in  1  data write request
- `d_writedata`  in  32  store data
- `d_byteenable`  in  4  store/load lane enables
- `d_waitrequest`  out  1  data stall
- `d_readdata`  out  32  load data
- `address`  out  32  slave address
- `read`  out  1  slave read
- `write`  out  1  slave write
- `writedata`  out  32  slave write data
- `byteenable`  out  4  slave byte enables
- `waitrequest`  in  1  slave stall
- `readdata`  in  32  slave read data
- `grant`  out  2  01 = fetch owns bus, 10 = data owns bus, 00 = idle
- `timeout_err`  out  1  sticky watchdog flag

## Operation
- The FSM has three states: IDLE, BUSY_I and BUSY_D. The state is registered, and the bus outputs are a combinational mux of that state.
- IDLE:
  - The bus drives `read`=`write`=0 and `address`/`writedata`=0. `byteenable`=0.
  - If `d_read`|`d_write` is high, go to BUSY_D. Data has priority on a tie.
  - Otherwise, if `i_read` is high, go to BUSY_I.
- BUSY_I:
  - The bus carries `i_address` and `read`=1, with `write`=0 and `byteenable`=4'b1111.
- BUSY_D:
  - The bus carries the `d_*` signals.
  - If `d_read` and `d_write` are both high, the write is forwarded and `read` is forced to 0.
- Completion: the owner's `*_waitrequest` equals the slave `waitrequest`, and `readdata` passes through to the owner.
- Next state on completion:
  - Go to the other BUSY state if the other master is requesting.
  - Otherwise go to IDLE.
  - The completing master is never re-granted directly.
- A non-owner master always sees `*_waitrequest`=1. Its `*_readdata` is 0.
- If the owner drops its request while granted, which is a protocol violation, go to IDLE without a bus transfer.

## Timing
- Reset values, applied asynchronously:
  - State IDLE.
  - `read`/`write`/`byteenable`/`address`/`writedata` = 0.
  - `i_waitrequest`=`d_waitrequest`=1.
  - `grant`=00, `timeout_err`=0, and the watchdog counter is 0.
- Reset asserted mid-transfer drops `read`/`write` immediately, in the same cycle, without waiting for a clock edge.
- The request is sampled in IDLE in cycle N. The bus is driven from cycle N+1.
- With a zero-wait slave, the master completes in N+1, giving 2-cycle latency from IDLE.
- Alternating masters run back-to-back with no bubble.
- The same master issuing consecutive requests incurs one IDLE cycle between transfers.
- Each slave-stall cycle extends the transfer by one cycle.
- `grant` is registered and reflects the current state.

## Configuration
- `MIPS_ARB_TIMEOUT_EN` defined:
  - A counter increments each BUSY cycle in which `waitrequest`=1, and clears on completion or in IDLE.
  - When the count reaches `TIMEOUT_CYCLES`, the arbiter forces the owner's `*_waitrequest`=0 with `*_readdata`=32'h0, and deasserts `read`/`write` that cycle.
  - In that cycle `timeout_err` is set; it clears only on reset. The next state then follows the normal completion rule.
- `MIPS_ARB_TIMEOUT_EN` undefined:
  - No counter is built.
  - The arbiter waits indefinitely on `waitrequest`.
  - `timeout_err` is tied to 0 and the parameter is ignored.

## Test plan
- Reset then fetch only, with `i_address`=0x0000_0010, slave returning 0x8C02_0004 at zero wait: bus `read`=1 in cycle N+1, `i_readdata`=0x8C02_0004, `i_waitrequest`=0 in N+1, `grant`=01.
- Simultaneous `i_read` and `d_write` (addr 0x100, data 0xDEAD_BEEF, byteenable 4'b0011): data is granted first and RAM bytes 0x100–0x101 are written as 0xEF, 0xBE. Fetch is granted the next cycle with no bubble.
- Slave `waitrequest` held high for 3 cycles during a data read: `d_waitrequest` stays 1 for 3 cycles then drops, `read` is held stable throughout, and `timeout_err` stays 0.
- With `MIPS_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, slave stalled forever: the owner is released in the 4th stalled cycle with `readdata` 0, `timeout_err`=1, and the flag is still 1 after 10 more cycles.
- Async `reset` pulled low mid data write: `write`=0 and `d_waitrequest`=1 before the next `clk` edge, and `grant`=00 after release.
- `d_read`=`d_write`=1 simultaneously: bus `write`=1 and `read`=0.
